// File: rtl/bus_drive_monitor.sv
// Bus drive monitor: flags split enables, unpermitted drives and multi-agent contention, with a sticky fault capture.
// Optional macro BUS_DRIVE_MONITOR_COUNT_EN builds the saturating offending-cycle counter.
module bus_drive_monitor #(
  parameter int AGENTS  = 2,
  parameter int WIDTH   = 16,
  parameter int GRACE   = 0,
  parameter int COUNT_W = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [AGENTS*WIDTH-1:0]   oe_i,
  input  logic [AGENTS-1:0]         permit_i,
  input  logic                      clear_i,
  output logic                      fault_o,
  output logic [2:0]                fault_kind_o,
  output logic [AGENTS-1:0]         fault_agents_o,
  output logic                      contention_o,
  output logic [COUNT_W-1:0]        fault_count_o
);

  typedef enum logic [1:0] {ST_OK, ST_GRACE, ST_FAULT} state_t;

  state_t              state_q, state_d, base_state;
  logic [3:0]          gcnt_q, gcnt_d, base_gcnt;
  logic [2:0]          kind_q, kind_d;
  logic [AGENTS-1:0]   agents_q, agents_d;
  logic                contention_q;
  logic [AGENTS-1:0]   drv, split, viol, implicated;
  logic                any_split, any_viol, contention, enter_fault;

  // Per-agent decode: driving at all, and driving only part of its slice
  always_comb begin
    drv   = '0;
    split = '0;
    for (int a = 0; a < AGENTS; a++) begin
      drv[a]   = |oe_i[a*WIDTH +: WIDTH];
      split[a] = drv[a] & ~(&oe_i[a*WIDTH +: WIDTH]);
    end
  end

  assign viol       = drv & ~permit_i;
  assign implicated = split | viol;
  assign any_split  = |split;
  assign any_viol   = |viol;
  assign contention = (drv & (drv - 1'b1)) != '0;

  // A clear restarts evaluation from OK so same-cycle offences re-enter FAULT with a fresh capture
  always_comb begin
    base_state  = clear_i ? ST_OK : state_q;
    base_gcnt   = clear_i ? 4'd0 : gcnt_q;
    state_d     = base_state;
    gcnt_d      = base_gcnt;
    kind_d      = clear_i ? 3'b000 : kind_q;
    agents_d    = clear_i ? '0 : agents_q;
    enter_fault = 1'b0;
    case (base_state)
      ST_OK: begin
        if (any_split || any_viol) begin
          enter_fault = 1'b1;
        end else if (contention) begin
          if (GRACE == 0) begin
            enter_fault = 1'b1;
          end else begin
            state_d = ST_GRACE;
            gcnt_d  = 4'd1;
          end
        end
      end
      ST_GRACE: begin
        if (any_split || any_viol) begin
          enter_fault = 1'b1;
        end else if (contention) begin
          if (base_gcnt == 4'(GRACE)) enter_fault = 1'b1;
          else                        gcnt_d = base_gcnt + 4'd1;
        end else begin
          state_d = ST_OK;
          gcnt_d  = 4'd0;
        end
      end
      ST_FAULT: ;
      default: begin
        state_d = ST_OK;
        gcnt_d  = 4'd0;
      end
    endcase
    if (enter_fault) begin
      state_d  = ST_FAULT;
      gcnt_d   = 4'd0;
      kind_d   = {any_viol, contention, any_split};
      agents_d = (implicated != '0) ? implicated : drv;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_OK;
      gcnt_q       <= 4'd0;
      kind_q       <= 3'b000;
      agents_q     <= '0;
      contention_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gcnt_q       <= gcnt_d;
      kind_q       <= kind_d;
      agents_q     <= agents_d;
      contention_q <= contention;
    end
  end

  assign fault_o        = (state_q == ST_FAULT);
  assign fault_kind_o   = kind_q;
  assign fault_agents_o = agents_q;
  assign contention_o   = contention_q;

`ifdef BUS_DRIVE_MONITOR_COUNT_EN
  logic               offending;
  logic [COUNT_W-1:0] count_q;

  assign offending = any_split | any_viol | contention;

  // Saturating count; a clear in an offending cycle leaves that cycle counted
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= offending ? COUNT_W'(1) : '0;
    end else if (offending && (count_q != '1)) begin
      count_q <= count_q + COUNT_W'(1);
    end
  end

  assign fault_count_o = count_q;
`else
  assign fault_count_o = '0;
`endif

endmodule

// File: tb/tb_bus_drive_monitor.sv
// Directed self-checking bench for bus_drive_monitor (AGENTS=3, WIDTH=8, GRACE=2, COUNT_W=4).
// Counter expectations follow BUS_DRIVE_MONITOR_COUNT_EN; without it the count must read 0.
module tb_bus_drive_monitor;

  localparam int AGENTS  = 3;
  localparam int WIDTH   = 8;
  localparam int GRACE   = 2;
  localparam int COUNT_W = 4;

  logic                    clk_i = 1'b0;
  logic                    reset_i;
  logic [AGENTS*WIDTH-1:0] oe_i;
  logic [AGENTS-1:0]       permit_i;
  logic                    clear_i;
  logic                    fault_o;
  logic [2:0]              fault_kind_o;
  logic [AGENTS-1:0]       fault_agents_o;
  logic                    contention_o;
  logic [COUNT_W-1:0]      fault_count_o;

  int checks = 0;
  int errors = 0;

  bus_drive_monitor #(
    .AGENTS(AGENTS), .WIDTH(WIDTH), .GRACE(GRACE), .COUNT_W(COUNT_W)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .oe_i(oe_i), .permit_i(permit_i),
    .clear_i(clear_i), .fault_o(fault_o), .fault_kind_o(fault_kind_o),
    .fault_agents_o(fault_agents_o), .contention_o(contention_o),
    .fault_count_o(fault_count_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] expCount(input int n);
`ifdef BUS_DRIVE_MONITOR_COUNT_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  task automatic applyStimulus(input logic [23:0] oe, input logic [2:0] permit, input logic clr);
    oe_i     = oe;
    permit_i = permit;
    clear_i  = clr;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic f, input logic [2:0] k,
                          input logic [2:0] a, input logic c, input int n);
    checkOutput({tag, ".fault"},  32'(fault_o),        32'(f));
    checkOutput({tag, ".kind"},   32'(fault_kind_o),   32'(k));
    checkOutput({tag, ".agents"}, 32'(fault_agents_o), 32'(a));
    checkOutput({tag, ".cont"},   32'(contention_o),   32'(c));
    checkOutput({tag, ".count"},  32'(fault_count_o),  expCount(n));
  endtask

  initial begin
    reset_i = 1'b1;
    applyStimulus(24'h0, 3'b000, 1'b0);
    #3;
    checkAll("reset", 1'b0, 3'b000, 3'b000, 1'b0, 0);
    #4 reset_i = 1'b0;

    // Clean single-agent full drive: never offending
    applyStimulus(24'h0000FF, 3'b001, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkAll("clean", 1'b0, 3'b000, 3'b000, 1'b0, 0);
    end

    // Split enable on agent0
    applyStimulus(24'h00000F, 3'b001, 1'b0);
    tick();
    checkAll("split0", 1'b1, 3'b001, 3'b001, 1'b0, 1);
    applyStimulus(24'h0, 3'b000, 1'b1);
    tick();
    checkAll("clear1", 1'b0, 3'b000, 3'b000, 1'b0, 0);
    clear_i = 1'b0;

    // Two-cycle contention stays within grace
    applyStimulus(24'h00FFFF, 3'b011, 1'b0);
    tick();
    checkAll("cont2a", 1'b0, 3'b000, 3'b000, 1'b1, 1);
    tick();
    checkAll("cont2b", 1'b0, 3'b000, 3'b000, 1'b1, 2);
    applyStimulus(24'h0, 3'b011, 1'b0);
    tick();
    checkAll("cont2rel", 1'b0, 3'b000, 3'b000, 1'b0, 2);

    // Three-cycle contention exhausts grace
    applyStimulus(24'h00FFFF, 3'b011, 1'b0);
    tick();
    tick();
    checkAll("cont3b", 1'b0, 3'b000, 3'b000, 1'b1, 4);
    tick();
    checkAll("cont3c", 1'b1, 3'b010, 3'b011, 1'b1, 5);
    applyStimulus(24'h0, 3'b000, 1'b1);
    tick();
    checkAll("clear2", 1'b0, 3'b000, 3'b000, 1'b0, 0);
    clear_i = 1'b0;

    // Unpermitted drive on agent2, held until the counter saturates
    applyStimulus(24'hFF0000, 3'b011, 1'b0);
    tick();
    checkAll("viol2", 1'b1, 3'b100, 3'b100, 1'b0, 1);
    for (int i = 0; i < 19; i++) tick();
    checkAll("satur", 1'b1, 3'b100, 3'b100, 1'b0, 15);

    // Clear coincident with a new split on agent1 re-captures immediately
    applyStimulus(24'h000F00, 3'b010, 1'b1);
    tick();
    checkAll("clrsplit", 1'b1, 3'b001, 3'b010, 1'b0, 1);
    applyStimulus(24'h0, 3'b000, 1'b0);
    tick();
    checkAll("sticky", 1'b1, 3'b001, 3'b010, 1'b0, 1);

    // Asynchronous reset mid-GRACE, then grace restarts from OK
    applyStimulus(24'h0, 3'b000, 1'b1);
    tick();
    applyStimulus(24'h00FFFF, 3'b011, 1'b0);
    tick();
    checkAll("grace", 1'b0, 3'b000, 3'b000, 1'b1, 1);
    reset_i = 1'b1;
    #1;
    checkAll("asyncrst", 1'b0, 3'b000, 3'b000, 1'b0, 0);
    #1 reset_i = 1'b0;
    tick();
    checkAll("post1", 1'b0, 3'b000, 3'b000, 1'b1, 1);
    tick();
    checkAll("post2", 1'b0, 3'b000, 3'b000, 1'b1, 2);
    tick();
    checkAll("post3", 1'b1, 3'b010, 3'b011, 1'b1, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
